cache_tagv_array: RTL and testbench

Parametrised N-way tag/valid store for the L1 caches, successor to the fixed 2-way instruction-cache tag array. The valid bit is packed with the tag in block RAM, so the array scales to large set counts. A sweep state machine clears the array after reset and on flush requests. Reads are registered, compare against a tag supplied one cycle later, and return one-hot hit, encoded hit index, multi-hit flag, and raw tags/valids for replacement logic.

---
 rtl/cache_tagv_array_if.sv | 43 ++++
 rtl/cache_tagv_array.sv | 179 +++++++++++++++++
 tb/tb_cache_tagv_array.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_tagv_array_if.sv
// Bus bundle for the N-way tag/valid array: read request and compare,
// write/invalidate request, flush pulse, and the hit/tag/valid results.
interface cache_tagv_array_if #(
   parameter int WAYS      = 2,
   parameter int SET_BITS  = 4,
   parameter int TAG_WIDTH = 20,
   parameter int IDX_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) ();

   logic                      ready;
   logic                      flush_req;

   logic                      rd_en;
   logic [SET_BITS-1:0]       rd_set;
   logic [TAG_WIDTH-1:0]      cmp_tag;
   logic [WAYS-1:0]           hit;
   logic                      hit_any;
   logic [IDX_W-1:0]          hit_idx;
   logic                      multi_hit;
   logic [WAYS*TAG_WIDTH-1:0] rd_tag;
   logic [WAYS-1:0]           rd_valid;

   logic                      wr_en;
   logic [WAYS-1:0]           wr_way;
   logic [SET_BITS-1:0]       wr_set;
   logic [TAG_WIDTH-1:0]      wr_tag;
   logic                      wr_valid;

   // Cache controller side: issues requests, consumes results
   modport master (
      input  ready, hit, hit_any, hit_idx, multi_hit, rd_tag, rd_valid,
      output flush_req, rd_en, rd_set, cmp_tag,
             wr_en, wr_way, wr_set, wr_tag, wr_valid
   );

   // Array side: accepts requests, produces results
   modport slave (
      output ready, hit, hit_any, hit_idx, multi_hit, rd_tag, rd_valid,
      input  flush_req, rd_en, rd_set, cmp_tag,
             wr_en, wr_way, wr_set, wr_tag, wr_valid
   );

endinterface

// File: rtl/cache_tagv_array.sv
// Parametrised N-way tag/valid store. Each way is a block RAM of
// {valid, tag} words with a registered read port. A sweep FSM zeroes every
// set after reset and on flush. Same-cycle read/write to one set is made
// write-first through a registered bypass, and the compare against cmp_tag
// happens combinationally in the cycle after the read.
module cache_tagv_array #(
   parameter int WAYS      = 2,
   parameter int SET_BITS  = 4,
   parameter int TAG_WIDTH = 20,
   parameter int IDX_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input logic               clk,
   input logic               rst,
   cache_tagv_array_if.slave bus
);

   localparam int                  SETS     = 1 << SET_BITS;
   localparam int                  WORD_W   = TAG_WIDTH + 1;
   localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [SET_BITS-1:0]        cnt_q, cnt_d;

   logic                       idle;
   logic                       sweep;
   logic                       rd_fire;
   logic                       wr_fire;
   logic [WAYS-1:0]            way_we;
   logic [SET_BITS-1:0]        wr_addr;
   logic [WORD_W-1:0]          wr_word;

   logic [WAYS-1:0]            byp_mask_q, byp_mask_d;
   logic [WORD_W-1:0]          byp_word_q, byp_word_d;

   logic [WAYS-1:0][WORD_W-1:0] ram_word;
   logic [WAYS-1:0]            hit_vec;

   // State register: reset always restarts the clearing sweep at set 0
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: sweep one set per cycle, the last set wraps cnt and ends the sweep
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT, ST_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SET) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (bus.flush_req) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs of the FSM: ready, request gating and the shared RAM write port
   always_comb begin
      idle      = (state_q == ST_IDLE);
      sweep     = (state_q == ST_INIT) || (state_q == ST_FLUSH);
      bus.ready = idle;
      rd_fire   = idle && bus.rd_en;
      wr_fire   = idle && bus.wr_en;
      way_we    = '0;
      wr_addr   = bus.wr_set;
      wr_word   = {bus.wr_valid, bus.wr_tag};
      if (sweep) begin
         way_we  = '1;
         wr_addr = cnt_q;
         wr_word = '0;
      end else if (wr_fire) begin
         way_we  = bus.wr_way;
      end
   end

   // Bypass capture: on each read remember which ways a same-set write overrides
   always_comb begin
      byp_mask_d = byp_mask_q;
      byp_word_d = byp_word_q;
      if (rd_fire) begin
         byp_mask_d = (wr_fire && (bus.wr_set == bus.rd_set)) ? bus.wr_way : '0;
         byp_word_d = {bus.wr_valid, bus.wr_tag};
      end
   end

   // Bypass registers follow the read output register, including its hold
   always_ff @(posedge clk) begin
      if (rst) begin
         byp_mask_q <= '0;
         byp_word_q <= '0;
      end else begin
         byp_mask_q <= byp_mask_d;
         byp_word_q <= byp_word_d;
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [WORD_W-1:0] mem [SETS];
      logic [WORD_W-1:0] rdata_d, rdata_q;

      // RAM write port, shared by the sweep and normal writes
      always_ff @(posedge clk) begin
         if (way_we[w]) begin
            mem[wr_addr] <= wr_word;
         end
      end

      // Read port: a new read loads the set, otherwise the last word is held
      always_comb begin
         rdata_d = rdata_q;
         if (rd_fire) begin
            rdata_d = mem[bus.rd_set];
         end
      end

      // Read output register, cleared by reset so outputs start at zero
      always_ff @(posedge clk) begin
         if (rst) begin
            rdata_q <= '0;
         end else begin
            rdata_q <= rdata_d;
         end
      end

      assign ram_word[w] = rdata_q;
   end

   // Merge bypass over RAM data, expose raw tags/valids and compare each way
   always_comb begin : merge_compare
      logic [WORD_W-1:0] word;
      word         = '0;
      hit_vec      = '0;
      bus.rd_valid = '0;
      bus.rd_tag   = '0;
      for (int w = 0; w < WAYS; w++) begin
         word = byp_mask_q[w] ? byp_word_q : ram_word[w];
         bus.rd_valid[w]                         = word[TAG_WIDTH];
         bus.rd_tag[w*TAG_WIDTH +: TAG_WIDTH]    = word[TAG_WIDTH-1:0];
         hit_vec[w] = idle && word[TAG_WIDTH] && (word[TAG_WIDTH-1:0] == bus.cmp_tag);
      end
   end

   // Hit summary: lowest hitting way wins the index, multi-hit flags overlap
   always_comb begin
      bus.hit_idx = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) begin
            bus.hit_idx = IDX_W'(w);
         end
      end
      bus.multi_hit = |(hit_vec & (hit_vec - 1'b1));
   end

   assign bus.hit     = hit_vec;
   assign bus.hit_any = |hit_vec;

endmodule

// File: tb/tb_cache_tagv_array.sv
// Scoreboard bench for cache_tagv_array: a 2-way/16-set instance and a
// 4-way/64-set instance. Reads push expected results into a queue; a monitor
// pops and compares in the cycle the array presents its read data.
module tb_cache_tagv_array;

   logic clk = 1'b0;
   logic rstA;
   logic rstB;

   always #5 clk = ~clk;

   cache_tagv_array_if #(.WAYS(2), .SET_BITS(4), .TAG_WIDTH(20)) busA ();
   cache_tagv_array_if #(.WAYS(4), .SET_BITS(6), .TAG_WIDTH(20)) busB ();

   cache_tagv_array #(.WAYS(2), .SET_BITS(4), .TAG_WIDTH(20)) dutA (
      .clk (clk),
      .rst (rstA),
      .bus (busA)
   );

   cache_tagv_array #(.WAYS(4), .SET_BITS(6), .TAG_WIDTH(20)) dutB (
      .clk (clk),
      .rst (rstB),
      .bus (busB)
   );

   typedef struct {
      string       name;
      logic [31:0] exp;
      int          tagWay;
   } expect_t;

   expect_t     qA[$];
   expect_t     qB[$];
   expect_t     eA;
   expect_t     eB;
   logic [31:0] actA;
   logic [31:0] actB;
   logic        pendA = 1'b0;
   logic        pendB = 1'b0;
   int          checks = 0;
   int          passes = 0;
   int          n;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         passes++;
      end
   endtask

   function automatic logic [31:0] packExp(input logic [3:0] hit, input logic [1:0] idx,
                                           input logic multi, input logic [3:0] valid,
                                           input logic [19:0] tag);
      return {hit, |hit, idx, multi, valid, tag};
   endfunction

   task automatic expectA(input string name, input logic [3:0] hit, input logic [1:0] idx,
                          input logic multi, input logic [3:0] valid, input int tagWay,
                          input logic [19:0] tag);
      expect_t e;
      e.name   = name;
      e.exp    = packExp(hit, idx, multi, valid, tag);
      e.tagWay = tagWay;
      qA.push_back(e);
   endtask

   task automatic expectB(input string name, input logic [3:0] hit, input logic [1:0] idx,
                          input logic multi, input logic [3:0] valid, input int tagWay,
                          input logic [19:0] tag);
      expect_t e;
      e.name   = name;
      e.exp    = packExp(hit, idx, multi, valid, tag);
      e.tagWay = tagWay;
      qB.push_back(e);
   endtask

   // One cycle of requests on the 2-way array; cmp_tag follows a read by a cycle
   task automatic applyStimulus(input logic rd, input logic [3:0] rset, input logic [19:0] ctag,
                                input logic wr, input logic [1:0] way, input logic [3:0] wset,
                                input logic [19:0] wtag, input logic wval, input logic fl);
      busA.rd_en     = rd;
      busA.rd_set    = rset;
      busA.wr_en     = wr;
      busA.wr_way    = way;
      busA.wr_set    = wset;
      busA.wr_tag    = wtag;
      busA.wr_valid  = wval;
      busA.flush_req = fl;
      @(posedge clk);
      #1;
      busA.rd_en     = 1'b0;
      busA.wr_en     = 1'b0;
      busA.flush_req = 1'b0;
      if (rd) busA.cmp_tag = ctag;
   endtask

   task automatic applyB(input logic rd, input logic [5:0] rset, input logic [19:0] ctag,
                         input logic wr, input logic [3:0] way, input logic [5:0] wset,
                         input logic [19:0] wtag, input logic wval);
      busB.rd_en    = rd;
      busB.rd_set   = rset;
      busB.wr_en    = wr;
      busB.wr_way   = way;
      busB.wr_set   = wset;
      busB.wr_tag   = wtag;
      busB.wr_valid = wval;
      @(posedge clk);
      #1;
      busB.rd_en = 1'b0;
      busB.wr_en = 1'b0;
      if (rd) busB.cmp_tag = ctag;
   endtask

   task automatic waitReady(input bit selB, output int cnt);
      cnt = 0;
      while (((selB) ? busB.ready : busA.ready) !== 1'b1 && cnt < 300) begin
         cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   always @(posedge clk) begin
      pendA <= busA.rd_en && busA.ready;
      pendB <= busB.rd_en && busB.ready;
   end

   always @(negedge clk) begin
      if (pendA) begin
         if (qA.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_read_A: read accepted, expected none queued");
         end else begin
            eA   = qA.pop_front();
            actA = {2'b00, busA.hit, busA.hit_any, 1'b0, busA.hit_idx, busA.multi_hit,
                    2'b00, busA.rd_valid, busA.rd_tag[eA.tagWay*20 +: 20]};
            checkOutput(eA.name, actA, eA.exp);
         end
      end
      if (pendB) begin
         if (qB.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_read_B: read accepted, expected none queued");
         end else begin
            eB   = qB.pop_front();
            actB = {busB.hit, busB.hit_any, busB.hit_idx, busB.multi_hit,
                    busB.rd_valid, busB.rd_tag[eB.tagWay*20 +: 20]};
            checkOutput(eB.name, actB, eB.exp);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstA = 1'b1;
      rstB = 1'b1;
      busA.rd_en = 1'b0; busA.rd_set = '0; busA.cmp_tag = '0; busA.flush_req = 1'b0;
      busA.wr_en = 1'b0; busA.wr_way = '0; busA.wr_set = '0; busA.wr_tag = '0; busA.wr_valid = 1'b0;
      busB.rd_en = 1'b0; busB.rd_set = '0; busB.cmp_tag = '0; busB.flush_req = 1'b0;
      busB.wr_en = 1'b0; busB.wr_way = '0; busB.wr_set = '0; busB.wr_tag = '0; busB.wr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      checkOutput("reset_outputs_A", 32'({busA.ready, busA.hit_any, busA.hit, busA.multi_hit,
                                          busA.hit_idx, busA.rd_valid, |busA.rd_tag}), 32'd0);
      checkOutput("reset_outputs_B", 32'({busB.ready, busB.hit_any, busB.hit, busB.multi_hit,
                                          busB.hit_idx, busB.rd_valid, |busB.rd_tag}), 32'd0);

      rstA = 1'b0;
      waitReady(1'b0, n);
      checkOutput("init_ready_low_cycles_A", 32'(n), 32'd16);

      for (int s = 0; s < 16; s++) begin
         expectA($sformatf("empty_after_init_set%0d", s), 4'b0000, 2'd0, 1'b0, 4'b0000, 0, 20'h0);
         applyStimulus(1'b1, 4'(s), (s % 2 == 0) ? 20'h00000 : 20'hFFFFF,
                       1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);
      end

      applyStimulus(1'b0, 4'd0, 20'h0, 1'b1, 2'b10, 4'd5, 20'h12345, 1'b1, 1'b0);
      expectA("hit_way1_set5", 4'b0010, 2'd1, 1'b0, 4'b0010, 1, 20'h12345);
      applyStimulus(1'b1, 4'd5, 20'h12345, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);
      expectA("miss_near_tag_set5", 4'b0000, 2'd0, 1'b0, 4'b0010, 1, 20'h12345);
      applyStimulus(1'b1, 4'd5, 20'h12344, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);

      expectA("bypass_refill_set3", 4'b0001, 2'd0, 1'b0, 4'b0001, 0, 20'h00ABC);
      applyStimulus(1'b1, 4'd3, 20'h00ABC, 1'b1, 2'b01, 4'd3, 20'h00ABC, 1'b1, 1'b0);
      expectA("bypass_invalidate_set3", 4'b0000, 2'd0, 1'b0, 4'b0000, 0, 20'h00ABC);
      applyStimulus(1'b1, 4'd3, 20'h00ABC, 1'b1, 2'b01, 4'd3, 20'h00ABC, 1'b0, 1'b0);
      expectA("ram_after_invalidate_set3", 4'b0000, 2'd0, 1'b0, 4'b0000, 0, 20'h00ABC);
      applyStimulus(1'b1, 4'd3, 20'h00ABC, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);
      expectA("bypass_cleared_set5", 4'b0010, 2'd1, 1'b0, 4'b0010, 0, 20'h00000);
      applyStimulus(1'b1, 4'd5, 20'h12345, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);

      applyStimulus(1'b0, 4'd0, 20'h0, 1'b1, 2'b11, 4'd9, 20'h00007, 1'b1, 1'b0);
      expectA("multi_hit_set9", 4'b0011, 2'd0, 1'b1, 4'b0011, 1, 20'h00007);
      applyStimulus(1'b1, 4'd9, 20'h00007, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);

      for (int s = 0; s < 16; s++) begin
         applyStimulus(1'b0, 4'd0, 20'h0, 1'b1, 2'b11, 4'(s), 20'(s + 256), 1'b1, 1'b0);
      end
      expectA("filled_set4", 4'b0011, 2'd0, 1'b1, 4'b0011, 1, 20'h00104);
      applyStimulus(1'b1, 4'd4, 20'h00104, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);

      applyStimulus(1'b0, 4'd0, 20'h0, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b1);
      checkOutput("flush_hits_forced_low", 32'({busA.ready, busA.hit_any, busA.hit, busA.multi_hit}),
                  32'd0);
      applyStimulus(1'b1, 4'd2, 20'h00102, 1'b1, 2'b11, 4'd2, 20'h00055, 1'b1, 1'b0);
      checkOutput("flush_dropped_read_no_hit", 32'({busA.hit_any, busA.hit}), 32'd0);
      waitReady(1'b0, n);
      checkOutput("flush_ready_low_cycles", 32'(n + 1), 32'd16);

      for (int s = 0; s < 16; s++) begin
         expectA($sformatf("empty_after_flush_set%0d", s), 4'b0000, 2'd0, 1'b0, 4'b0000, 0, 20'h0);
         applyStimulus(1'b1, 4'(s), 20'(s + 256), 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);
      end

      applyStimulus(1'b0, 4'd0, 20'h0, 1'b1, 2'b11, 4'd15, 20'h003FF, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'd0, 20'h0, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b1);
      repeat (7) @(posedge clk);
      #1;
      rstA = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_mid_flush_outputs", 32'({busA.ready, busA.hit_any, busA.hit, busA.multi_hit,
                                                busA.rd_valid, |busA.rd_tag}), 32'd0);
      rstA = 1'b0;
      waitReady(1'b0, n);
      checkOutput("rst_mid_flush_ready_low_cycles", 32'(n), 32'd16);
      expectA("after_restart_set15", 4'b0000, 2'd0, 1'b0, 4'b0000, 1, 20'h0);
      applyStimulus(1'b1, 4'd15, 20'h003FF, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);
      expectA("after_restart_set0", 4'b0000, 2'd0, 1'b0, 4'b0000, 0, 20'h0);
      applyStimulus(1'b1, 4'd0, 20'h00100, 1'b0, 2'b00, 4'd0, 20'h0, 1'b0, 1'b0);

      rstB = 1'b0;
      waitReady(1'b1, n);
      checkOutput("init_ready_low_cycles_B", 32'(n), 32'd64);
      applyB(1'b0, 6'd0, 20'h0, 1'b1, 4'b1000, 6'd40, 20'h0BEEF, 1'b1);
      expectB("b_way3_hit_set40", 4'b1000, 2'd3, 1'b0, 4'b1000, 3, 20'h0BEEF);
      applyB(1'b1, 6'd40, 20'h0BEEF, 1'b0, 4'b0000, 6'd0, 20'h0, 1'b0);
      applyB(1'b0, 6'd0, 20'h0, 1'b1, 4'b0010, 6'd40, 20'h0BEEF, 1'b1);
      expectB("b_way1_way3_multi", 4'b1010, 2'd1, 1'b1, 4'b1010, 1, 20'h0BEEF);
      applyB(1'b1, 6'd40, 20'h0BEEF, 1'b0, 4'b0000, 6'd0, 20'h0, 1'b0);
      expectB("b_set63_empty", 4'b0000, 2'd0, 1'b0, 4'b0000, 3, 20'h0);
      applyB(1'b1, 6'd63, 20'h0BEEF, 1'b0, 4'b0000, 6'd0, 20'h0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(qA.size() + qB.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
